regfile_dump_reader: RTL and testbench

//   Read-side sequencer for the processor register file: on START, walks every

---
 rtl/regfile_dump_reader.sv | 142 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose:
//   Read-side sequencer for the processor register file. On start it walks
//   every register address, reads each word through the register file's
//   combinational read port and streams (address, data) pairs downstream over
//   a valid/ready handshake. This block only reads; it never writes.
//
// Configuration macro:
//   REGDUMP_SKIP_ZERO_EN - when defined, the walk begins at address 1 so the
//                          hard-wired $zero register is never read or emitted
//                          (NUM_REGS-1 words per dump). When undefined, the
//                          walk begins at address 0 (NUM_REGS words).
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   start_i      begin a dump; only looked at while idle
//   rd_addr_o    address driven to the register file read port
//   rd_data_i    register file read data (combinational from rd_addr_o)
//   out_valid_o  out_addr_o/out_data_o hold a word for downstream
//   out_ready_i  downstream accepts the word when out_valid_o & out_ready_i
//   out_addr_o   address of the word on out_data_o
//   out_data_o   captured register value
//   busy_o       high while a dump is reading or sending
//   done_o       one-cycle pulse after the last word has been accepted
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        FIN
    } state_e;

    // Terminal address is tied to the number of registers actually present,
    // so a register file smaller than 2**ADDR_W never wraps the counter.
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

`ifdef REGDUMP_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FirstAddr = '0;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] outAddr_q;
    logic [DATA_W-1:0] outData_q;
    logic              outValid_q;
    logic              busy_q;
    logic              done_q;

    // Address of the next register to visit once the current word is taken.
    always_comb begin
        addr_d = addr_q + ADDR_W'(1);
    end

    // Dump sequencer. Every output is a flop so downstream sees glitch-free
    // handshake signals; busy/done are set on the transition into the state
    // they describe rather than decoded from state_q.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            outAddr_q  <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q  <= FirstAddr;
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    // The read port is combinational, so the word for addr_q
                    // is already on rd_data_i at the end of this cycle.
                    outData_q  <= rd_data_i;
                    outAddr_q  <= addr_q;
                    outValid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    // Holding registers stay untouched until the handshake,
                    // so a stalled word is never re-read.
                    if (out_ready_i) begin
                        outValid_q <= 1'b0;
                        if (addr_q == LastAddr) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            addr_q  <= addr_d;
                            state_q <= READ;
                        end
                    end
                end
                FIN: begin
                    // Park the read address back at 0 for the idle period.
                    addr_q  <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr_o   = addr_q;
    assign out_valid_o = outValid_q;
    assign out_addr_o  = outAddr_q;
    assign out_data_o  = outData_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Purpose:
//   Self-checking bench for regfile_dump_reader. A small register file array
//   feeds the read port; the expected word stream of each dump is built up
//   front as a queue of (address, data) pairs and popped on every handshake.
//   Honours REGDUMP_SKIP_ZERO_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_regfile_dump_reader;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [ADDR_W-1:0] out_addr_o;
    logic [DATA_W-1:0] out_data_o;
    logic              busy_o;
    logic              done_o;

    logic [DATA_W-1:0] regs [NUM_REGS];

    int errors = 0;
    int checks = 0;
    int firstAddr;
    int nWords;

    regfile_dump_reader #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_addr_o  (out_addr_o),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    // Behavioural register file: combinational read port.
    assign rd_data_i = regs[rd_addr_o];

    // One comparison: counts it, and on mismatch reports tag/observed/expected.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one dump from start to done (or to an injected reset) and checks
    // every word, the handshake hold behaviour and the done/busy timing.
    //   readyMode   0: ready held high, 1: random ready
    //   startAtWord pulse start while this address is being sent (-1: never)
    //   abortAtWord assert reset while this address is being sent (-1: never)
    //   stallWord   hold ready low 5 cycles on this address (-1: never)
    task automatic applyStimulus(input int readyMode, input int startAtWord,
                                 input int abortAtWord, input int stallWord);
        logic [ADDR_W-1:0] expAddr[$];
        logic [DATA_W-1:0] expData[$];
        int cycle;
        int stallLeft;
        bit firstSeen;
        bit startPulsed;
        bit finished;
        bit aborted;
        bit pending;

        for (int a = firstAddr; a < NUM_REGS; a++) begin
            expAddr.push_back(ADDR_W'(a));
            expData.push_back(regs[a]);
        end
        cycle       = 0;
        stallLeft   = 5;
        firstSeen   = 1'b0;
        startPulsed = 1'b0;
        finished    = 1'b0;
        aborted     = 1'b0;
        pending     = 1'b0;
        out_ready_i = 1'b1;
        start_i     = 1'b1;

        while (!finished && cycle < 400) begin
            @(posedge clk_i);
            #1;
            cycle++;
            start_i = 1'b0;
            if (pending) begin
                checkOutput("valid_held", out_valid_o, 1);
            end
            if (done_o) begin
                checkOutput("done_busy", busy_o, 0);
                checkOutput("done_valid", out_valid_o, 0);
                checkOutput("words_left", expAddr.size(), 0);
                if (readyMode == 0 && stallWord < 0) begin
                    checkOutput("done_cycle", cycle, 2 * nWords + 1);
                end
                finished = 1'b1;
            end else begin
                checkOutput("busy", busy_o, 1);
                if (out_valid_o) begin
                    if (!firstSeen) begin
                        firstSeen = 1'b1;
                        checkOutput("first_valid_cycle", cycle, 2);
                    end
                    if (expAddr.size() == 0) begin
                        checkOutput("extra_word", out_valid_o, 0);
                        finished = 1'b1;
                    end else begin
                        checkOutput("out_addr", out_addr_o, expAddr[0]);
                        checkOutput("out_data", out_data_o, expData[0]);
                        if (abortAtWord >= 0 && int'(expAddr[0]) == abortAtWord) begin
                            out_ready_i = 1'b0;
                            rst_ni      = 1'b0;
                            @(posedge clk_i);
                            #1;
                            checkOutput("abort_valid", out_valid_o, 0);
                            checkOutput("abort_busy", busy_o, 0);
                            checkOutput("abort_done", done_o, 0);
                            checkOutput("abort_rd_addr", rd_addr_o, 0);
                            rst_ni = 1'b1;
                            @(posedge clk_i);
                            #1;
                            checkOutput("abort_no_done", done_o, 0);
                            aborted  = 1'b1;
                            finished = 1'b1;
                        end else begin
                            if (int'(expAddr[0]) == stallWord && stallLeft > 0) begin
                                out_ready_i = 1'b0;
                                stallLeft--;
                            end else if (readyMode == 1) begin
                                out_ready_i = ($urandom_range(0, 3) != 0);
                            end else begin
                                out_ready_i = 1'b1;
                            end
                            if (startAtWord >= 0 && int'(expAddr[0]) == startAtWord && !startPulsed) begin
                                start_i     = 1'b1;
                                startPulsed = 1'b1;
                            end
                            if (out_ready_i) begin
                                void'(expAddr.pop_front());
                                void'(expData.pop_front());
                            end
                        end
                    end
                end else if (readyMode == 1) begin
                    // Ready while nothing is valid must have no effect.
                    out_ready_i = $urandom_range(0, 1) != 0;
                end
            end
            pending = out_valid_o && !out_ready_i && !aborted;
        end

        if (!finished) begin
            checkOutput("dump_timeout", finished, 1);
        end else if (!aborted) begin
            // Exactly one done, no queued restart, read address parked at 0.
            for (int k = 0; k < 3; k++) begin
                @(posedge clk_i);
                #1;
                checkOutput("post_done", done_o, 0);
                checkOutput("post_busy", busy_o, 0);
                checkOutput("post_rd_addr", rd_addr_o, 0);
            end
        end
        out_ready_i = 1'b0;
        start_i     = 1'b0;
    endtask

    initial begin
`ifdef REGDUMP_SKIP_ZERO_EN
        firstAddr = 1;
`else
        firstAddr = 0;
`endif
        nWords = NUM_REGS - firstAddr;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = 32'hA000_0000 + 32'(i);
        end

        $display("[TB] reset with start held high");
        rst_ni  = 1'b0;
        start_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_valid", out_valid_o, 0);
        checkOutput("rst_addr", out_addr_o, 0);
        checkOutput("rst_data", out_data_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_rd_addr", rd_addr_o, 0);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("idle_busy", busy_o, 0);

        $display("[TB] full dump, ready high");
        applyStimulus(0, -1, -1, -1);

        $display("[TB] backpressure on word 3");
        applyStimulus(0, -1, -1, 3);

        $display("[TB] start pulsed during word 10");
        applyStimulus(0, 10, -1, -1);

        $display("[TB] reset during word 7");
        applyStimulus(0, -1, 7, -1);

        $display("[TB] restart after reset");
        applyStimulus(0, -1, -1, -1);

        $display("[TB] random data and random ready");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] = $urandom;
            end
            applyStimulus(1, -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
